// File: rtl/sweep_sequencer.sv
// Segment scheduler for a triangle-wave sweep generator: plays a table of
// {minval, maxval, stepsize, dwell} entries with an off-gap between segments.
module sweep_sequencer #(
   parameter int NUM_SEG    = 4,
   parameter int GAP_CYCLES = 16,
   localparam int SEG_W     = $clog2(NUM_SEG)
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                cfg_we_in,
   input  logic [SEG_W+1:0]    cfg_addr_in,
   input  logic [31:0]         cfg_data_in,
   input  logic [SEG_W-1:0]    last_seg_in,
   input  logic                loop_in,
   input  logic                start_in,
   input  logic                abort_in,
   input  logic                hold_req_in,
   output logic                sweep_on_out,
   output logic                sweep_hold_out,
   output logic signed [15:0]  minval_out,
   output logic signed [15:0]  maxval_out,
   output logic [31:0]         stepsize_out,
   output logic [SEG_W-1:0]    seg_idx_out,
   output logic                busy_out,
   output logic                done_out
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [SEG_W-1:0]   idx, idx_nxt;
   logic [31:0]        dwell_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               hold_q;

   logic signed [15:0] tbl_min   [NUM_SEG];
   logic signed [15:0] tbl_max   [NUM_SEG];
   logic [31:0]        tbl_step  [NUM_SEG];
   logic [31:0]        tbl_dwell [NUM_SEG];

   logic [1:0]         cfg_field;
   logic [SEG_W-1:0]   cfg_seg;

   assign cfg_field = cfg_addr_in[1:0];
   assign cfg_seg   = cfg_addr_in[SEG_W+1:2];

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         S_IDLE: begin
            if (start_in && !abort_in) begin
               state_nxt = S_LOAD;
               idx_nxt   = '0;
            end
         end
         S_LOAD: state_nxt = S_RUN;
         S_RUN: begin
            if (!hold_req_in && dwell_cnt == 32'd1) state_nxt = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               // A last_seg below the current index ends the sequence too.
               if (idx < last_seg_in) begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = S_LOAD;
               end else if (loop_in) begin
                  idx_nxt   = '0;
                  state_nxt = S_LOAD;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort_in && state != S_IDLE) begin
         state_nxt = S_IDLE;
         idx_nxt   = idx;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= S_IDLE;
         idx          <= '0;
         dwell_cnt    <= '0;
         gap_cnt      <= '0;
         hold_q       <= 1'b0;
         minval_out   <= '0;
         maxval_out   <= '0;
         stepsize_out <= '0;
         for (int i = 0; i < NUM_SEG; i++) begin
            tbl_min[i]   <= '0;
            tbl_max[i]   <= '0;
            tbl_step[i]  <= '0;
            tbl_dwell[i] <= '0;
         end
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         // Hold is only forwarded while the segment keeps running.
         hold_q <= (state == S_RUN && state_nxt == S_RUN) ? hold_req_in : 1'b0;

         if (state == S_LOAD && state_nxt == S_RUN) begin
            minval_out   <= tbl_min[idx];
            maxval_out   <= tbl_max[idx];
            stepsize_out <= tbl_step[idx];
            dwell_cnt    <= (tbl_dwell[idx] == 32'd0) ? 32'd1 : tbl_dwell[idx];
         end else if (state == S_RUN && !hold_req_in && dwell_cnt > 32'd1) begin
            dwell_cnt <= dwell_cnt - 32'd1;
         end

         if (state == S_RUN && state_nxt == S_GAP)
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
         else if (state == S_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;

         if (cfg_we_in) begin
            unique case (cfg_field)
               2'd0: tbl_min[cfg_seg]   <= cfg_data_in[15:0];
               2'd1: tbl_max[cfg_seg]   <= cfg_data_in[15:0];
               2'd2: tbl_step[cfg_seg]  <= cfg_data_in;
               2'd3: tbl_dwell[cfg_seg] <= cfg_data_in;
               default: ;
            endcase
         end
      end
   end

   assign sweep_on_out   = (state == S_RUN);
   assign sweep_hold_out = hold_q;
   assign seg_idx_out    = idx;
   assign busy_out       = (state != S_IDLE);
   assign done_out       = (state == S_DONE) && !abort_in;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Randomised and directed bench for sweep_sequencer against a timeline model
// built from segment durations (LOAD, dwell + held cycles, gap, done).
module tb_sweep_sequencer;

   localparam int NUM_SEG = 4;
   localparam int SEG_W   = 2;
   localparam int GAP     = 16;

   logic               clk_in = 1'b0;
   logic               rst_in = 1'b0;
   logic               cfg_we_in = 1'b0;
   logic [SEG_W+1:0]   cfg_addr_in = '0;
   logic [31:0]        cfg_data_in = '0;
   logic [SEG_W-1:0]   last_seg_in = '0;
   logic               loop_in = 1'b0;
   logic               start_in = 1'b0;
   logic               abort_in = 1'b0;
   logic               hold_req_in = 1'b0;
   logic               sweep_on_out, sweep_hold_out;
   logic signed [15:0] minval_out, maxval_out;
   logic [31:0]        stepsize_out;
   logic [SEG_W-1:0]   seg_idx_out;
   logic               busy_out, done_out;

   sweep_sequencer #(.NUM_SEG(NUM_SEG), .GAP_CYCLES(GAP)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cfg_we_in(cfg_we_in),
      .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in),
      .last_seg_in(last_seg_in), .loop_in(loop_in), .start_in(start_in),
      .abort_in(abort_in), .hold_req_in(hold_req_in),
      .sweep_on_out(sweep_on_out), .sweep_hold_out(sweep_hold_out),
      .minval_out(minval_out), .maxval_out(maxval_out),
      .stepsize_out(stepsize_out), .seg_idx_out(seg_idx_out),
      .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
   endtask

   // Reference: table contents and the values currently shown on the outputs
   logic signed [15:0] m_min [NUM_SEG];
   logic signed [15:0] m_max [NUM_SEG];
   logic [31:0]        m_step [NUM_SEG];
   logic [31:0]        m_dwell [NUM_SEG];
   logic signed [15:0] d_min, d_max;
   logic [31:0]        d_step;

   typedef struct {
      bit on; bit hold; bit busy; bit done; int idx;
      logic signed [15:0] mn; logic signed [15:0] mx; logic [31:0] st;
   } exp_t;

   exp_t tr[$];
   bit   hold_drv[$];
   bit   loop_drv[$];
   int   wr_cycle, abort_at, rst_at;
   int   wr_seg, wr_field;
   logic [31:0] wr_data;

   function automatic exp_t mk(bit on, bit hold, bit busy, bit done, int idx);
      exp_t e;
      e.on = on; e.hold = hold; e.busy = busy; e.done = done; e.idx = idx;
      e.mn = d_min; e.mx = d_max; e.st = d_step;
      return e;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NUM_SEG; i++) begin
         m_min[i] = '0; m_max[i] = '0; m_step[i] = '0; m_dwell[i] = '0;
      end
      d_min = '0; d_max = '0; d_step = '0;
   endtask

   task automatic model_write(input int seg, input int field, input logic [31:0] data);
      case (field)
         0: m_min[seg]   = data[15:0];
         1: m_max[seg]   = data[15:0];
         2: m_step[seg]  = data;
         default: m_dwell[seg] = data;
      endcase
   endtask

   // Expected timeline from the start pulse: per played segment one LOAD cycle,
   // dwell (min 1) plus held cycles of RUN, GAP off cycles; then DONE and IDLE.
   task automatic build(input int last, input int passes, input int hold_play,
                        input int hold_off, input int hold_len, input int wr_play);
      int nplay;
      nplay = passes * (last + 1);
      tr.delete(); hold_drv.delete(); loop_drv.delete();
      wr_cycle = -1; abort_at = -1; rst_at = -1;
      for (int j = 0; j < nplay; j++) begin
         int s, dw, held;
         bit lp, prev, hin;
         s  = j % (last + 1);
         lp = (passes > 1);
         tr.push_back(mk(0, 0, 1, 0, s)); hold_drv.push_back(0); loop_drv.push_back(lp);
         d_min = m_min[s]; d_max = m_max[s]; d_step = m_step[s];
         dw   = (m_dwell[s] == 0) ? 1 : int'(m_dwell[s]);
         held = (j == hold_play) ? hold_len : 0;
         if (j == wr_play) wr_cycle = tr.size();
         prev = 0;
         for (int r = 0; r < dw + held; r++) begin
            hin = (j == hold_play) && (r >= hold_off) && (r < hold_off + hold_len);
            tr.push_back(mk(1, prev, 1, 0, s)); hold_drv.push_back(hin); loop_drv.push_back(lp);
            prev = hin;
         end
         if (j == wr_play) model_write(wr_seg, wr_field, wr_data);
         for (int g = 0; g < GAP; g++) begin
            tr.push_back(mk(0, 0, 1, 0, s)); hold_drv.push_back(0);
            loop_drv.push_back((j == nplay - 1) ? 1'b0 : lp);
         end
      end
      tr.push_back(mk(0, 0, 1, 1, last)); hold_drv.push_back(0); loop_drv.push_back(0);
      for (int k = 0; k < 3; k++) begin
         tr.push_back(mk(0, 0, 0, 0, last)); hold_drv.push_back(0); loop_drv.push_back(0);
      end
   endtask

   // Truncate the timeline with an abort or reset asserted during cycle a.
   task automatic cut(input int a, input bit is_rst);
      exp_t e;
      e = tr[a];
      e.done = 0;
      tr[a] = e;
      while (tr.size() > a + 1) begin
         void'(tr.pop_back()); void'(hold_drv.pop_back()); void'(loop_drv.pop_back());
      end
      if (is_rst) begin
         rst_at = a;
         model_clear();
      end else begin
         abort_at = a;
         d_min = e.mn; d_max = e.mx; d_step = e.st;
      end
      for (int k = 0; k < 3; k++) begin
         tr.push_back(mk(0, 0, 0, 0, is_rst ? 0 : e.idx));
         hold_drv.push_back(0); loop_drv.push_back(0);
      end
   endtask

   task automatic compare(input int t);
      exp_t e;
      e = tr[t];
      check($sformatf("on@%0d", t),   32'(sweep_on_out),   32'(e.on));
      check($sformatf("hold@%0d", t), 32'(sweep_hold_out), 32'(e.hold));
      check($sformatf("busy@%0d", t), 32'(busy_out),       32'(e.busy));
      check($sformatf("done@%0d", t), 32'(done_out),       32'(e.done));
      check($sformatf("idx@%0d", t),  32'(seg_idx_out),    32'(e.idx));
      check($sformatf("min@%0d", t),  32'(minval_out),     32'(e.mn));
      check($sformatf("max@%0d", t),  32'(maxval_out),     32'(e.mx));
      check($sformatf("step@%0d", t), stepsize_out,        e.st);
   endtask

   task automatic play(input int last);
      last_seg_in = SEG_W'(last);
      loop_in     = loop_drv[0];
      @(posedge clk_in); #1;
      start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      for (int t = 0; t < tr.size(); t++) begin
         hold_req_in = hold_drv[t];
         loop_in     = loop_drv[t];
         abort_in    = (t == abort_at);
         rst_in      = (t == rst_at);
         cfg_we_in   = (t == wr_cycle);
         if (t == wr_cycle) begin
            cfg_addr_in = {SEG_W'(wr_seg), 2'(wr_field)};
            cfg_data_in = wr_data;
         end
         @(negedge clk_in);
         compare(t);
         @(posedge clk_in); #1;
      end
      hold_req_in = 0; loop_in = 0; abort_in = 0; rst_in = 0; cfg_we_in = 0;
   endtask

   task automatic write_cfg(input int seg, input int field, input logic [31:0] data);
      @(posedge clk_in); #1;
      cfg_we_in   = 1'b1;
      cfg_addr_in = {SEG_W'(seg), 2'(field)};
      cfg_data_in = data;
      @(posedge clk_in); #1;
      cfg_we_in = 1'b0;
      model_write(seg, field, data);
   endtask

   task automatic write_seg(input int seg, input int mn, input int mx,
                            input logic [31:0] st, input logic [31:0] dw);
      write_cfg(seg, 0, 32'(mn));
      write_cfg(seg, 1, 32'(mx));
      write_cfg(seg, 2, st);
      write_cfg(seg, 3, dw);
   endtask

   task automatic do_reset();
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      model_clear();
   endtask

   initial begin
      int a, last, passes, nplay, hp, hoff, hlen, s, dw;

      do_reset();
      @(negedge clk_in);
      check("rst_on", 32'(sweep_on_out), 0);
      check("rst_hold", 32'(sweep_hold_out), 0);
      check("rst_busy", 32'(busy_out), 0);
      check("rst_done", 32'(done_out), 0);
      check("rst_idx", 32'(seg_idx_out), 0);
      check("rst_min", 32'(minval_out), 0);
      check("rst_max", 32'(maxval_out), 0);
      check("rst_step", stepsize_out, 0);

      // Single segment, 100-cycle dwell
      write_seg(0, -1000, 1000, 32'h0001_0000, 100);
      build(0, 1, -1, 0, 0, -1);
      play(0);

      // Three segments, dwell 10/20/30
      write_seg(0, -100, 100, 32'd7, 10);
      write_seg(1, -200, 300, 32'd9, 20);
      write_seg(2, -5, 5, 32'd11, 30);
      build(2, 1, -1, 0, 0, -1);
      play(2);

      // Hold for 7 cycles inside a 50-cycle dwell
      write_seg(0, -50, 50, 32'd3, 50);
      build(0, 1, 0, 20, 7, -1);
      play(0);

      // Loop over segments 0..1 twice, loop cleared in the final gap
      write_seg(0, -10, 10, 32'd1, 4);
      write_seg(1, -20, 20, 32'd2, 6);
      build(1, 2, -1, 0, 0, -1);
      play(1);

      // Abort in the RUN window of segment 1
      write_seg(0, -30, 30, 32'd5, 5);
      write_seg(1, -40, 40, 32'd6, 8);
      write_seg(2, -50, 50, 32'd7, 5);
      build(2, 1, -1, 0, 0, -1);
      a = 0;
      for (int t = 0; t < tr.size(); t++)
         if (a == 0 && tr[t].on && tr[t].idx == 1) a = t + 3;
      cut(a, 0);
      play(2);

      // start and abort together in IDLE must not start
      @(posedge clk_in); #1;
      start_in = 1'b1; abort_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0; abort_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         check($sformatf("sa_busy%0d", k), 32'(busy_out), 0);
         check($sformatf("sa_on%0d", k), 32'(sweep_on_out), 0);
         check($sformatf("sa_done%0d", k), 32'(done_out), 0);
         @(posedge clk_in); #1;
      end

      // maxval rewritten while segment 0 is active, looping on segment 0
      write_seg(0, -300, 1000, 32'd5, 12);
      wr_seg = 0; wr_field = 1; wr_data = 32'd500;
      build(0, 2, -1, 0, 0, 0);
      play(0);

      // Zero dwell gives a one-cycle on-window
      write_seg(0, -1, 1, 32'd2, 0);
      build(0, 1, -1, 0, 0, -1);
      play(0);

      // Reset in the middle of a gap
      write_seg(0, -70, 70, 32'd4, 6);
      write_seg(1, -80, 80, 32'd8, 6);
      build(1, 1, -1, 0, 0, -1);
      a = 0;
      for (int t = 1; t < tr.size(); t++)
         if (a == 0 && tr[t-1].on && !tr[t].on) a = t + 5;
      cut(a, 1);
      play(1);

      // Randomised sequences with optional hold and abort
      for (int it = 0; it < 10; it++) begin
         for (int sg = 0; sg < NUM_SEG; sg++)
            write_seg(sg, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768,
                      $urandom, $urandom_range(0, 12));
         last   = $urandom_range(0, NUM_SEG - 1);
         passes = $urandom_range(1, 2);
         nplay  = passes * (last + 1);
         hp = -1; hoff = 0; hlen = 0;
         if ($urandom_range(0, 1) == 1) begin
            hp   = $urandom_range(0, nplay - 1);
            s    = hp % (last + 1);
            dw   = (m_dwell[s] == 0) ? 1 : int'(m_dwell[s]);
            hoff = $urandom_range(0, dw - 1);
            hlen = $urandom_range(1, 5);
         end
         build(last, passes, hp, hoff, hlen, -1);
         if ($urandom_range(0, 3) == 0) cut($urandom_range(0, tr.size() - 4), 0);
         play(last);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
Programmable scheduler that drives the on/hold/minval/maxval/stepsize controls of a triangle-wave sweep generator.
- Holds a table of NUM_SEG sweep segments, each with minval, maxval, stepsize and dwell.
- On start, plays segments 0..last_seg_in in order. Each segment runs for a fixed dwell time, then the sweep is turned off for GAP_CYCLES so it resets to zero.
- Sits between the host register interface and the sweep generator in the servo signal path.

Parameters:
NUM_SEG, 4, number of table segments; power of 2, 2..16. SEG_W = log2(NUM_SEG).
GAP_CYCLES, 16, cycles sweep_on_out is held low between segments; must be >= 1.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
cfg_we_in  input  1  table write strobe
cfg_addr_in  input  SEG_W+2  {segment, field}. Field 0 = minval, 1 = maxval, 2 = stepsize, 3 = dwell.
cfg_data_in  input  32  write data; minval/maxval use [15:0] as signed
last_seg_in  input  SEG_W  index of final segment in sequence
loop_in  input  1  1 = restart at segment 0 after last segment
start_in  input  1  start pulse
abort_in  input  1  abort pulse
hold_req_in  input  1  request sweep hold (freezes dwell count)
sweep_on_out  output  1  to sweep on input
sweep_hold_out  output  1  to sweep hold input
minval_out  output  16 signed  to sweep minval
maxval_out  output  16 signed  to sweep maxval
stepsize_out  output  32  to sweep stepsize
seg_idx_out  output  SEG_W  currently active segment
busy_out  output  1  high in any state but IDLE
done_out  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset: all table entries cleared to 0; state IDLE; seg_idx_out = 0; all outputs 0.
- Table writes:
  - Accepted on any cycle cfg_we_in = 1, including while busy.
  - Take effect at the next LOAD of that segment; active outputs never change mid-segment.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE:
  - sweep_on_out = 0, sweep_hold_out = 0.
  - start_in = 1 and abort_in = 0 -> LOAD with index 0.
  - start_in with abort_in in the same cycle -> stay in IDLE.
- LOAD (1 cycle):
  - Register table[idx] onto minval_out, maxval_out and stepsize_out.
  - Load dwell counter with dwell; dwell = 0 is treated as 1.
  - seg_idx_out = idx; sweep_on_out stays 0.
  - Next state RUN.
- RUN:
  - sweep_on_out = 1.
  - sweep_hold_out is a registered copy of hold_req_in (1-cycle latency).
  - Dwell counter decrements only on cycles where hold_req_in = 0.
  - Segment therefore lasts exactly dwell non-held cycles plus held cycles.
  - When counter == 1 and hold_req_in = 0 -> GAP.
  - sweep_hold_out is forced to 0 on exit from RUN.
- GAP:
  - sweep_on_out = 0 for exactly GAP_CYCLES cycles; the sweep generator zeroes itself.
  - Then:
    - idx != last_seg_in -> idx + 1, LOAD.
    - idx == last_seg_in and loop_in = 1 -> idx = 0, LOAD.
    - idx == last_seg_in and loop_in = 0 -> DONE.
  - last_seg_in and loop_in are sampled at GAP exit.
  - last_seg_in below the current idx ends the sequence as if idx == last_seg_in.
- DONE (1 cycle): done_out = 1, then IDLE. minval/maxval/stepsize outputs retain their last values.
- abort_in in LOAD, RUN, GAP or DONE:
  - Next cycle IDLE with sweep_on_out = 0 and sweep_hold_out = 0.
  - No done_out pulse; seg_idx_out retains its value.
  - Abort has priority over all other transitions.
- start_in while busy is ignored.
- Reset mid-operation returns to reset state on the next edge, regardless of state.
- busy_out = 1 in every state except IDLE, including DONE.
- Dwell counter is 32 bits, unsigned; it never wraps (stops at 1).

Test Plan:
- Seg0 = {min -1000, max 1000, step 0x10000, dwell 100}; last_seg = 0; loop = 0; start. Require:
  - LOAD on cycle 1, then sweep_on_out high for exactly 100 cycles.
  - Low for 16 cycles, then done_out pulse, then busy_out low.
  - minval_out/maxval_out = -1000/1000.
- Segs 0..2 with dwell 10/20/30, last_seg = 2. Require seg_idx_out sequence 0, 1, 2 with on-windows of 10, 20, 30 cycles, each separated by 16 off cycles plus 1 LOAD cycle.
- Hold during RUN: dwell 50, hold_req_in high for 7 cycles mid-segment. Require:
  - sweep_hold_out high for 7 cycles, delayed by 1 cycle.
  - sweep_on_out window = 57 cycles.
- loop_in = 1 with last_seg = 1. Require idx sequence 0, 1, 0, 1, ... with no done_out. Clear loop_in during the second segment-1 GAP -> done_out at GAP exit.
- abort_in during RUN of seg 1. Require sweep_on_out = 0 the next cycle, IDLE, no done_out.
  - Also: start_in + abort_in together in IDLE -> no start.
  - Also: rst_in during GAP -> all outputs 0.
- Write seg0 maxval = 500 while seg0 is active with loop_in = 1, last_seg = 0. Require maxval_out unchanged until the next LOAD, then 500. Also: dwell = 0 yields a 1-cycle on-window.
